// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response, execute
// redirect, and the decoded-instruction handshake toward decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, ins_valid, ins, ins_pc,
               op_code, funct3, funct7, rd, rs1, rs2,
               fetch_fault, fetch_count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req, imem_addr, ins_valid, ins, ins_pc,
               op_code, funct3, funct7, rd, rs1, rs2,
               fetch_fault, fetch_count,
        output imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time, holds the
// returned instruction until decode takes it, follows execute redirects and
// locks up in FAULT on a misaligned redirect target until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ins_q;
    logic [31:0] ins_pc_q;
    logic        ins_valid_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic        redirect_aligned;
    logic        redirect_misaligned;

    assign redirect_aligned    = bus.redirect && (bus.redirect_pc[1:0] == 2'b00);
    assign redirect_misaligned = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

    // Request is a pure state decode, forced low while reset is held
    assign bus.imem_req  = (state == FETCH) && !rst;
    assign bus.imem_addr = pc;

    // Instruction outputs and field slices straight off the held word
    assign bus.ins_valid   = ins_valid_q;
    assign bus.ins         = ins_q;
    assign bus.ins_pc      = ins_pc_q;
    assign bus.op_code     = ins_q[6:0];
    assign bus.rd          = ins_q[11:7];
    assign bus.funct3      = ins_q[14:12];
    assign bus.rs1         = ins_q[19:15];
    assign bus.rs2         = ins_q[24:20];
    assign bus.funct7      = ins_q[31:25];
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_count = count_q;

    // Fetch FSM with all of its registered state in one place
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            ins_q       <= 32'h0;
            ins_pc_q    <= 32'h0;
            ins_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_misaligned) begin
                        state       <= FAULT;
                        fault_q     <= 1'b1;
                        ins_valid_q <= 1'b0;
                    end else if (redirect_aligned) begin
                        pc          <= bus.redirect_pc;
                        ins_valid_q <= 1'b0;
                    end else if (bus.imem_ack) begin
                        ins_q       <= bus.imem_rdata;
                        ins_pc_q    <= pc;
                        ins_valid_q <= 1'b1;
                        pc          <= pc + 32'd4;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // A handshake counts even when a redirect lands with it
                    if (ins_valid_q && bus.ins_ready) begin
                        count_q <= count_q + 32'd1;
                    end
                    if (redirect_misaligned) begin
                        state       <= FAULT;
                        fault_q     <= 1'b1;
                        ins_valid_q <= 1'b0;
                    end else if (redirect_aligned) begin
                        pc          <= bus.redirect_pc;
                        ins_valid_q <= 1'b0;
                        state       <= FETCH;
                    end else if (bus.ins_ready) begin
                        ins_valid_q <= 1'b0;
                        state       <= FETCH;
                    end
                end
                FAULT: begin
                    ins_valid_q <= 1'b0;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule
